// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with iterative multiply/divide
// Purpose: registered single-cycle rotate/shift/add/logic ops plus shift-add
//   unsigned multiply and restoring unsigned divide/remainder, one op in flight.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   request handshake; ready only while IDLE
//   A, B, Cin, Op        operands, ADD carry-in, opcode; B[CW-1:0] is shift count
//   invA, invB, sign     operand inversion, ADD overflow mode (1 signed)
//   out_valid, out_ready result handshake; result held until taken
//   Out, Zero, Ofl, Err  result and flags, stable while out_valid
//   busy                 state != IDLE
module alu_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [3:0]   Op,
  input  logic         invA,
  input  logic         invB,
  input  logic         sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         Zero,
  output logic         Ofl,
  output logic         Err,
  output logic         busy
);
  localparam int CW = $clog2(N);
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  // acc: product high half / partial remainder; lo: multiplier / quotient;
  // opnd: multiplicand / divisor.
  logic [N-1:0]  acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [N-1:0]  out_q, out_d;
  logic          zero_q, zero_d, ofl_q, ofl_d, err_q, err_d;
  logic          load;

  logic [N-1:0]  in_a, in_b;
  logic [CW-1:0] sh_cnt;
  logic [CW:0]   sh_inv;
  logic [N:0]    add_sum;
  logic [N-1:0]  single_res;
  logic          single_ofl;

  logic [N:0]    mul_sum;
  logic [N:0]    div_sh;
  logic          div_ge;
  logic [N-1:0]  div_diff;
  logic [N-1:0]  acc_step, lo_step;

  assign in_a    = invA ? ~A : A;
  assign in_b    = invB ? ~B : B;
  assign sh_cnt  = in_b[CW-1:0];
  // Complementary shift for rotates; equals N when sh_cnt is 0, which
  // shifts everything out so the rotate degenerates to a plain copy.
  assign sh_inv  = (CW+1)'(N) - {1'b0, sh_cnt};
  assign add_sum = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, Cin};

  always_comb begin
    single_res = '0;
    single_ofl = 1'b0;
    case (Op[2:0])
      3'd0: single_res = (in_a << sh_cnt) | (in_a >> sh_inv);
      3'd1: single_res = in_a << sh_cnt;
      3'd2: single_res = (in_a >> sh_cnt) | (in_a << sh_inv);
      3'd3: single_res = in_a >> sh_cnt;
      3'd4: begin
        single_res = add_sum[N-1:0];
        single_ofl = sign ? ((in_a[N-1] == in_b[N-1]) && (add_sum[N-1] != in_a[N-1]))
                          : add_sum[N];
      end
      3'd5: single_res = in_a & in_b;
      3'd6: single_res = in_a | in_b;
      3'd7: single_res = in_a ^ in_b;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_q, lo_q[N-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  // Partial remainder stays below the divisor, so the difference fits N bits.
  assign div_diff = div_sh[N-1:0] - opnd_q;
  assign acc_step = (op_q == OP_MUL) ? mul_sum[N:1]
                  : (div_ge ? div_diff : div_sh[N-1:0]);
  assign lo_step  = (op_q == OP_MUL) ? {mul_sum[0], lo_q[N-1:1]}
                  : {lo_q[N-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ofl_d   = ofl_q;
    err_d   = err_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = Op;
          ofl_d = 1'b0;
          err_d = 1'b0;
          if (!Op[3]) begin
            out_d   = single_res;
            ofl_d   = single_ofl;
            load    = 1'b1;
            state_d = DONE;
          end else if (Op == OP_MUL) begin
            acc_d   = '0;
            lo_d    = in_b;
            opnd_d  = in_a;
            cnt_d   = '0;
            state_d = BUSY;
          end else if ((Op == OP_DIV) || (Op == OP_REM)) begin
            if (in_b == '0) begin
              out_d   = (Op == OP_DIV) ? '1 : in_a;
              err_d   = 1'b1;
              load    = 1'b1;
              state_d = DONE;
            end else begin
              acc_d   = '0;
              lo_d    = in_a;
              opnd_d  = in_b;
              cnt_d   = '0;
              state_d = BUSY;
            end
          end else begin
            out_d   = '0;
            err_d   = 1'b1;
            load    = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          out_d   = (op_q == OP_REM) ? acc_step : lo_step;
          ofl_d   = (op_q == OP_MUL) && (acc_step != '0);
          load    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) zero_d = (out_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ofl_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ofl_q   <= ofl_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Out       = out_q;
  assign Zero      = zero_q;
  assign Ofl       = ofl_q;
  assign Err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (N=16 and N=32 instances)
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0, sign = 1'b0, inva = 1'b0, invb = 1'b0;
  logic [3:0]  op = 4'd0;
  logic        in_valid16 = 1'b0, in_valid32 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready16, out_valid16, zero16, ofl16, err16, busy16;
  logic        in_ready32, out_valid32, zero32, ofl32, err32, busy32;
  logic [15:0] out16;
  logic [31:0] out32;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .Cin(cin), .Op(op), .invA(inva), .invB(invb), .sign(sign),
    .out_valid(out_valid16), .out_ready(out_ready), .Out(out16), .Zero(zero16),
    .Ofl(ofl16), .Err(err16), .busy(busy16));

  alu_seq #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .Cin(cin), .Op(op), .invA(inva), .invB(invb), .sign(sign),
    .out_valid(out_valid32), .out_ready(out_ready), .Out(out32), .Zero(zero32),
    .Ofl(ofl32), .Err(err32), .busy(busy32));

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    bit          cin, sign, inva, invb;
    logic [15:0] exp_out;
    bit          exp_ofl, exp_err, exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] o, logic [15:0] a, logic [15:0] b, bit c, bit s,
                              bit ia, bit ib, logic [15:0] eo, bit eov, bit ee, bit ez, int el);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.cin = c; v.sign = s; v.inva = ia; v.invb = ib;
    v.exp_out = eo; v.exp_ofl = eov; v.exp_err = ee; v.exp_zero = ez; v.exp_lat = el;
    return v;
  endfunction

  task automatic cmp(input string nm, input longint unsigned got, input longint unsigned exp);
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      n_miss++;
    end
  endtask

  // Reference: plain arithmetic on 64-bit values, width w.
  function automatic void model(input int w, input logic [3:0] opc,
                                input longint unsigned a0, input longint unsigned b0,
                                input bit ci, input bit sg, input bit ia, input bit ib,
                                output longint unsigned o, output bit ofl, output bit err,
                                output bit zero, output int lat);
    longint unsigned mask, a, b, s, p;
    longint sa, sb, ss, lim;
    int c;
    mask = (64'd1 << w) - 64'd1;
    a = (ia ? ~a0 : a0) & mask;
    b = (ib ? ~b0 : b0) & mask;
    c = int'(b % 64'(w));
    o = 0; ofl = 0; err = 0; lat = 1;
    case (opc)
      4'd0: o = ((a << c) | (a >> (w - c))) & mask;
      4'd1: o = (a << c) & mask;
      4'd2: o = ((a >> c) | (a << (w - c))) & mask;
      4'd3: o = a >> c;
      4'd4: begin
        s = a + b + 64'(ci);
        o = s & mask;
        if (sg) begin
          lim = longint'(64'd1 << (w - 1));
          sa = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
          sb = (b >= 64'(lim)) ? longint'(b) - 2 * lim : longint'(b);
          ss = sa + sb + longint'(ci);
          ofl = (ss >= lim) || (ss < -lim);
        end else begin
          ofl = (s > mask);
        end
      end
      4'd5: o = a & b;
      4'd6: o = a | b;
      4'd7: o = a ^ b;
      4'd8: begin p = a * b; o = p & mask; ofl = (p >> w) != 0; lat = w + 1; end
      4'd9: if (b == 0) begin o = mask; err = 1; end else begin o = a / b; lat = w + 1; end
      4'd10: if (b == 0) begin o = a; err = 1; end else begin o = a % b; lat = w + 1; end
      default: err = 1;
    endcase
    zero = (o == 0);
  endfunction

  // Called away from the active edge; returns just after a negedge.
  task automatic run_op(input bit s32, input logic [3:0] opc, input longint unsigned a,
                        input longint unsigned b, input bit ci, input bit sg, input bit ia,
                        input bit ib, output longint unsigned got, output bit g_ofl,
                        output bit g_err, output bit g_zero, output int lat);
    op = opc; cin = ci; sign = sg; inva = ia; invb = ib;
    a16 = a[15:0]; b16 = b[15:0]; a32 = a[31:0]; b32 = b[31:0];
    if (s32) in_valid32 = 1'b1; else in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_valid32 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(s32 ? out_valid32 : out_valid16) && lat < 200);
    if (!(s32 ? out_valid32 : out_valid16)) begin
      $display("FAIL timeout: out_valid never rose for op %0h", opc);
      n_miss++;
    end
    got    = s32 ? {32'b0, out32} : {48'b0, out16};
    g_ofl  = s32 ? ofl32 : ofl16;
    g_err  = s32 ? err32 : err16;
    g_zero = s32 ? zero32 : zero16;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
  endtask

  initial begin
    longint unsigned got, e_o, ra, rb;
    bit g_ofl, g_err, g_zero, e_ofl, e_err, e_zero;
    int lat, e_lat;
    logic [3:0] rop;
    bit rci, rsg, ria, rib;

    tbl.push_back(mk(4'h4, 16'h7FFF, 16'h0001, 0, 1, 0, 0, 16'h8000, 1, 0, 0, 1));
    tbl.push_back(mk(4'h4, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0, 0, 0, 1));
    tbl.push_back(mk(4'h0, 16'h8001, 16'h0004, 0, 0, 0, 0, 16'h0018, 0, 0, 0, 1));
    tbl.push_back(mk(4'h1, 16'h8001, 16'h0004, 0, 0, 0, 0, 16'h0010, 0, 0, 0, 1));
    tbl.push_back(mk(4'h2, 16'h8001, 16'h0004, 0, 0, 0, 0, 16'h1800, 0, 0, 0, 1));
    tbl.push_back(mk(4'h3, 16'h8001, 16'h0004, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 1));
    tbl.push_back(mk(4'h8, 16'd300, 16'd300, 0, 0, 0, 0, 16'h5F90, 1, 0, 0, 17));
    tbl.push_back(mk(4'h8, 16'd12, 16'd11, 0, 0, 0, 0, 16'd132, 0, 0, 0, 17));
    tbl.push_back(mk(4'h9, 16'd100, 16'd7, 0, 0, 0, 0, 16'd14, 0, 0, 0, 17));
    tbl.push_back(mk(4'hA, 16'd100, 16'd7, 0, 0, 0, 0, 16'd2, 0, 0, 0, 17));
    tbl.push_back(mk(4'h9, 16'd100, 16'd0, 0, 0, 0, 0, 16'hFFFF, 0, 1, 0, 1));
    tbl.push_back(mk(4'hA, 16'd100, 16'd0, 0, 0, 0, 0, 16'd100, 0, 1, 0, 1));
    tbl.push_back(mk(4'hB, 16'h1234, 16'h0001, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1));
    tbl.push_back(mk(4'hF, 16'h1234, 16'h0001, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1));
    tbl.push_back(mk(4'h4, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(4'h4, 16'h8000, 16'h8000, 0, 1, 0, 0, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(4'h5, 16'h00F0, 16'h0F00, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(4'h6, 16'h00F0, 16'h0F00, 0, 0, 0, 0, 16'h0FF0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h7, 16'h00FF, 16'h0F0F, 0, 0, 1, 0, 16'hF00F, 0, 0, 0, 1));
    tbl.push_back(mk(4'h5, 16'h00FF, 16'h0F0F, 0, 0, 0, 1, 16'h00F0, 0, 0, 0, 1));

    repeat (3) @(negedge clk);
    cmp("reset out16", out16, 0);
    cmp("reset flags16", {zero16, ofl16, err16, out_valid16, busy16, in_ready16}, 6'b000001);
    cmp("reset flags32", {zero32, ofl32, err32, out_valid32, busy32, in_ready32}, 6'b000001);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(0, tbl[i].op, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].cin, tbl[i].sign,
             tbl[i].inva, tbl[i].invb, got, g_ofl, g_err, g_zero, lat);
      cmp($sformatf("vec%0d out", i), got, 64'(tbl[i].exp_out));
      cmp($sformatf("vec%0d ofl", i), 64'(g_ofl), 64'(tbl[i].exp_ofl));
      cmp($sformatf("vec%0d err", i), 64'(g_err), 64'(tbl[i].exp_err));
      cmp($sformatf("vec%0d zero", i), 64'(g_zero), 64'(tbl[i].exp_zero));
      cmp($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
    end

    // Backpressure: result held 5 cycles while a new request waits.
    op = 4'h8; a16 = 16'd12; b16 = 16'd11; inva = 0; invb = 0;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid16 && lat < 200);
    cmp("bp mul latency", 64'(lat), 17);
    op = 4'h6; a16 = 16'h00F0; b16 = 16'h0F00;
    in_valid16 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp($sformatf("bp hold%0d out", k), 64'(out16), 132);
      cmp($sformatf("bp hold%0d valid/ready", k), {out_valid16, in_ready16}, 2'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    cmp("bp after handshake valid/ready", {out_valid16, in_ready16}, 2'b01);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(negedge clk);
    cmp("bp next valid", 64'(out_valid16), 1);
    cmp("bp next out", 64'(out16), 64'h0FF0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec += 2;

    // Reset in the middle of a multiply.
    op = 4'h8; a16 = 16'd300; b16 = 16'd300;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    cmp("mid-mul busy", 64'(busy16), 1);
    rst_n = 1'b0;
    #1;
    cmp("abort valid/busy/ready", {out_valid16, busy16, in_ready16}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    run_op(0, 4'h6, 64'h00F0, 64'h0F00, 0, 0, 0, 0, got, g_ofl, g_err, g_zero, lat);
    cmp("post-reset or out", got, 64'h0FF0);
    cmp("post-reset or latency", 64'(lat), 1);

    // Wider instance: multiply latency N+1.
    run_op(1, 4'h8, 64'd300, 64'd300, 0, 0, 0, 0, got, g_ofl, g_err, g_zero, lat);
    cmp("n32 mul out", got, 64'd90000);
    cmp("n32 mul ofl", 64'(g_ofl), 0);
    cmp("n32 mul latency", 64'(lat), 33);

    for (int i = 0; i < 160; i++) begin
      bit s32;
      s32 = (i >= 140);
      rop = 4'($urandom_range(0, 15));
      ra  = 64'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom);
      if (!s32) begin ra &= 64'hFFFF; if ($urandom_range(0, 1) == 1) rb &= 64'h001F; end
      rci = 1'($urandom); rsg = 1'($urandom);
      ria = ($urandom_range(0, 3) == 0); rib = ($urandom_range(0, 3) == 0);
      model(s32 ? 32 : 16, rop, ra, rb, rci, rsg, ria, rib, e_o, e_ofl, e_err, e_zero, e_lat);
      run_op(s32, rop, ra, rb, rci, rsg, ria, rib, got, g_ofl, g_err, g_zero, lat);
      cmp($sformatf("rand%0d op%0h out", i, rop), got, e_o);
      cmp($sformatf("rand%0d op%0h flags", i, rop), {g_ofl, g_err, g_zero}, {e_ofl, e_err, e_zero});
      cmp($sformatf("rand%0d op%0h latency", i, rop), 64'(lat), 64'(e_lat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
